// File: rtl/recirc_mux_sync_rx_pkg.sv
// recirc_sync_pkg: mode constants and parameter legality checks shared by the recirculation-mux synchronizer
package recirc_sync_pkg;
  localparam int MODE_LEVEL = 0;
  localparam int MODE_TOGGLE = 1;
  function automatic bit params_ok(int width, int channels, int stages, int mode, int cnt_w);
    return width >= 1 && channels >= 1 && stages >= 2 && cnt_w >= 1 &&
           (mode == MODE_LEVEL || mode == MODE_TOGGLE);
  endfunction
endpackage

// File: rtl/recirc_mux_sync_rx_if.sv
// recirc_mux_sync_rx_if: source-side enable/data bus and destination-side results of the synchronizer
interface recirc_mux_sync_rx_if #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W = 8
);
  logic [CHANNELS-1:0] async_en;
  logic [CHANNELS*WIDTH-1:0] async_data;
  logic cnt_clr;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [CHANNELS-1:0] data_valid;
  logic [CHANNELS-1:0] ack;
  logic [CHANNELS-1:0] sync_en;
  logic [CHANNELS*CNT_W-1:0] cap_count;
  modport master (
    output async_en, async_data, cnt_clr,
    input data_out, data_valid, ack, sync_en, cap_count
  );
  modport slave (
    input async_en, async_data, cnt_clr,
    output data_out, data_valid, ack, sync_en, cap_count
  );
endinterface

// File: rtl/recirc_mux_sync_rx_chan.sv
// recirc_sync_chan: one channel - enable synchronizer, recirculating hold register, output stage, ack and counter
module recirc_sync_chan
  import recirc_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE = MODE_LEVEL,
  parameter int CNT_W = 8
) (
  input  logic             clk2,
  input  logic             rst_clk2,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ack_o,
  output logic             sync_en_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic en_d_q, load_q, valid_q, ack_q, ack_d, load;
  logic [WIDTH-1:0] hold_q, hold_d, out_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], en_i};
    load = (MODE == MODE_TOGGLE) ? sync_q[SYNC_STAGES-1] ^ en_d_q : sync_q[SYNC_STAGES-1];
    hold_d = load ? data_i : hold_q;
    cnt_d = cnt_clr_i ? '0 : cnt_q + CNT_W'(load);
    ack_d = ack_q ^ load_q;
  end
  // load_q lines valid/ack up with the output register, one cycle after the hold register
  always_ff @(posedge clk2) begin
    if (rst_clk2) begin
      sync_q <= '0;
      en_d_q <= 1'b0;
      hold_q <= '0;
      out_q <= '0;
      load_q <= 1'b0;
      valid_q <= 1'b0;
      ack_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      en_d_q <= sync_q[SYNC_STAGES-1];
      hold_q <= hold_d;
      out_q <= hold_q;
      load_q <= load;
      valid_q <= load_q;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_o = out_q;
  assign valid_o = valid_q;
  assign ack_o = (MODE == MODE_TOGGLE) ? ack_q : en_d_q;
  assign sync_en_o = sync_q[SYNC_STAGES-1];
  assign cnt_o = cnt_q;
endmodule

// File: rtl/recirc_mux_sync_rx.sv
// recirc_mux_sync_rx: multi-channel receive-side recirculation-mux synchronizer in the clk2 domain
module recirc_mux_sync_rx
  import recirc_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE = MODE_LEVEL,
  parameter int CNT_W = 8
) (
  input logic clk2,
  input logic rst_clk2,
  recirc_mux_sync_rx_if.slave bus
);
  if (!params_ok(WIDTH, CHANNELS, SYNC_STAGES, MODE, CNT_W)) begin : g_bad
    $error("recirc_mux_sync_rx: illegal parameter set");
  end
  logic [CHANNELS*WIDTH-1:0] data_out_w;
  logic [CHANNELS-1:0] valid_w, ack_w, sync_en_w;
  logic [CHANNELS*CNT_W-1:0] cnt_w;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    recirc_sync_chan #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .MODE(MODE),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk2(clk2),
      .rst_clk2(rst_clk2),
      .en_i(bus.async_en[c]),
      .data_i(bus.async_data[c*WIDTH +: WIDTH]),
      .cnt_clr_i(bus.cnt_clr),
      .data_o(data_out_w[c*WIDTH +: WIDTH]),
      .valid_o(valid_w[c]),
      .ack_o(ack_w[c]),
      .sync_en_o(sync_en_w[c]),
      .cnt_o(cnt_w[c*CNT_W +: CNT_W])
    );
  end
  assign bus.data_out = data_out_w;
  assign bus.data_valid = valid_w;
  assign bus.ack = ack_w;
  assign bus.sync_en = sync_en_w;
  assign bus.cap_count = cnt_w;
endmodule

// File: doc/recirc_mux_sync_rx.md
# recirc_mux_sync_rx

Parametrised, multi-channel receive-side recirculation-mux synchronizer. It sits entirely in the destination clock domain. It synchronizes a per-channel enable launched from a foreign domain, captures that channel's quasi-static data bus into a recirculating hold register, and registers the result out. It generalises the single-bit level-enable scheme in three ways:

- configurable width, channel count and synchronizer depth;
- a toggle (pulse-handshake) mode with an ack return;
- per-channel valid strobes and capture counters.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, flops in each enable synchronizer (>=2)
- MODE, 0, 0 = level mode, 1 = toggle mode; applies to all channels
- CNT_W, 8, capture-counter width per channel

Ports:
- clk2, in, 1, destination clock; one clock; reset is synchronous and active-high
- rst_clk2, in, 1, synchronous active-high reset
- async_en, in, CHANNELS, per-channel enable from the source domain; asynchronous to clk2
- async_data, in, CHANNELS*WIDTH, channel c occupies [c*WIDTH +: WIDTH]; source holds it stable from the enable change until ack/deassert
- cnt_clr, in, 1, synchronous clear of all capture counters
- data_out, out, CHANNELS*WIDTH, registered captured data
- data_valid, out, CHANNELS, one-cycle-per-load strobe aligned with the data_out update
- ack, out, CHANNELS, handshake return to the source domain
- sync_en, out, CHANNELS, synchronized enable level (last synchronizer stage)
- cap_count, out, CHANNELS*CNT_W, per-channel load count

## Operation
- Per channel, async_en passes through SYNC_STAGES flops; the last stage is sync_en. A further flop, en_d, holds sync_en delayed by one cycle.
- Load condition:
  - MODE 0: load = sync_en.
  - MODE 1: load = sync_en XOR en_d (either edge).
- Hold register: loads async_data when load is true; otherwise recirculates its own value. async_data is sampled only when the synchronized enable qualifies it.
- data_out is the hold register delayed one cycle.
- data_valid is the load condition delayed one cycle.
- ack:
  - MODE 1: toggles on every load, at the same edge data_out updates. The source must not toggle async_en again until ack equals its toggle.
  - MODE 0: ack = en_d.
- cap_count: increments by 1 per load and wraps from 2^CNT_W-1 to 0. cnt_clr clears every counter; clear wins over a simultaneous load (result 0).
- Channels are fully independent. Simultaneous loads on multiple channels are all honoured in the same cycle.
- Reset values: all synchronizer flops, en_d, hold, data_out, data_valid, ack, sync_en and cap_count are 0.
- Reset mid-operation: state is discarded immediately at the reset edge.
  - MODE 1: if async_en is 1 at reset release, the chain rises 0 to 1, which produces exactly one capture. Intended behaviour, so the source re-initialises.
  - MODE 0: loads resume SYNC_STAGES+1 cycles after release if async_en is held high.

## Timing
- Let edge k be the first clk2 edge that samples a new async_en value.
- sync_en changes at edge k+SYNC_STAGES-1.
- The hold register loads at edge k+SYNC_STAGES.
- data_out, data_valid and ack (MODE 1 toggle) update at edge k+SYNC_STAGES+1, and cap_count updates at edge k+SYNC_STAGES, when the hold register loads. Total latency SYNC_STAGES+1 from enable sampling.
- MODE 0 with the enable held high: data_valid is high every cycle and data_out tracks async_data with the same latency.
- MODE 0 after the enable drops: the last loaded value holds indefinitely.
- MODE 1: two toggles closer than one clk2 period may merge and are a protocol violation. Toggles at least SYNC_STAGES+2 cycles apart always produce distinct captures.

## Structure
- Package recirc_sync_pkg: MODE_LEVEL=0 and MODE_TOGGLE=1 constants, plus the parameter legality checks (SYNC_STAGES>=2, WIDTH>=1).
- Sub-module recirc_sync_chan: one channel (synchronizer, en_d, hold register, output register, valid, ack, counter). The top instantiates it CHANNELS times in a generate loop and slices the flat buses.

## Test plan
- Reset: apply rst_clk2 with async_en=all ones and data nonzero -> every output is 0 during reset and on the first cycle after it.
- MODE 0, SYNC_STAGES=2, ch0 data 0xA5, enable raised at edge k:
  - data_out[7:0]=0xA5 and data_valid[0]=1 from edge k+3.
  - Data changed to 0x3C after the enable drops: data_out stays 0xA5.
- MODE 1, three toggles 10 cycles apart with data 0x11/0x22/0x33 -> exactly three data_valid pulses, data_out sequence 0x11,0x22,0x33, ack toggles three times, cap_count=3.
- Counter wrap with CNT_W=2: 5 loads -> cap_count 1,2,3,0,1. cnt_clr asserted on a load cycle -> cap_count=0.
- Channel independence, CHANNELS=4: toggle ch1 and ch3 on the same edge with different data -> both load in the same cycle; ch0/ch2 data_out, valid and counters are unchanged.
- Reset mid-capture: assert rst_clk2 one cycle after the hold register loads -> data_out=0 and no data_valid pulse after reset, except the single documented MODE 1 capture when async_en=1 at release.
